// File: rtl/obi_arb_pkg.sv
// Shared constants and the round-robin pick function for the OBI arbiter.
package obi_arb_pkg;

    localparam int unsigned N_MST_DEF   = 2;
    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned MAX_OUT_DEF = 4;
    localparam int unsigned MAX_MST     = 8;
    localparam int unsigned MST_IDX_W   = 3;

    // First requesting master at or after ptr, scanning upward modulo n_mst.
    function automatic logic [MST_IDX_W-1:0] rr_pick(
        input logic [MAX_MST-1:0]   req,
        input logic [MST_IDX_W-1:0] ptr,
        input int unsigned          n_mst
    );
        logic        found;
        int unsigned idx;
        found   = 1'b0;
        rr_pick = ptr;
        for (int unsigned i = 0; i < MAX_MST; i++) begin
            idx = (32'(ptr) + i) % n_mst;
            if (!found && (i < n_mst) && req[MST_IDX_W'(idx)]) begin
                found   = 1'b1;
                rr_pick = MST_IDX_W'(idx);
            end
        end
    endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// In-order response-ID FIFO; full/empty derived from the occupancy count.
module obi_id_fifo #(
    parameter int unsigned ID_W  = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [ID_W-1:0]            id_i,
    input  logic                       pop_i,
    output logic [ID_W-1:0]            id_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [ID_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        full_o  = (count_q == CNT_W'(DEPTH));
        empty_o = (count_q == '0);
        id_o    = mem_q[rptr_q];
        count_o = count_q;
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        if (do_push) begin
            mem_d[wptr_q] = id_i;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when the count says valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/obi_arbiter.sv
// N-to-1 round-robin OBI arbiter with request lock and in-order response routing.
module obi_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned N_MST   = N_MST_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [N_MST-1:0]                   m_req_i,
    output logic [N_MST-1:0]                   m_gnt_o,
    input  logic [N_MST-1:0][ADDR_W-1:0]       m_addr_i,
    input  logic [N_MST-1:0]                   m_we_i,
    input  logic [N_MST-1:0][DATA_W/8-1:0]     m_be_i,
    input  logic [N_MST-1:0][DATA_W-1:0]       m_wdata_i,
    output logic [N_MST-1:0]                   m_rvalid_o,
    output logic [N_MST-1:0][DATA_W-1:0]       m_rdata_o,
    output logic                               s_req_o,
    input  logic                               s_gnt_i,
    output logic [ADDR_W-1:0]                  s_addr_o,
    output logic                               s_we_o,
    output logic [DATA_W/8-1:0]                s_be_o,
    output logic [DATA_W-1:0]                  s_wdata_o,
    input  logic                               s_rvalid_i,
    input  logic [DATA_W-1:0]                  s_rdata_i,
    output logic [$clog2(MAX_OUT):0]           outstanding_o,
    output logic                               err_o
);

    localparam int unsigned IDX_W = $clog2(N_MST);
    localparam int unsigned CNT_W = $clog2(MAX_OUT) + 1;

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]   winner_c, head_id;
    logic               lock_q, lock_d, err_q, err_d;
    logic               fifo_full, fifo_empty, hs, pop;
    logic [CNT_W-1:0]   fifo_count;
    logic [MAX_MST-1:0] req_ext;

    always_comb begin
        req_ext             = '0;
        req_ext[N_MST-1:0]  = m_req_i;
        winner_c   = lock_q ? lock_idx_q
                            : IDX_W'(rr_pick(req_ext, MST_IDX_W'(rr_ptr_q), N_MST));
        s_req_o    = rst_ni && !fifo_full && (lock_q || (|m_req_i));
        hs         = s_req_o && s_gnt_i;
        pop        = rst_ni && s_rvalid_i && !fifo_empty;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        s_addr_o   = '0;
        s_we_o     = 1'b0;
        s_be_o     = '0;
        s_wdata_o  = '0;
        for (int unsigned i = 0; i < N_MST; i++) begin
            if (winner_c == IDX_W'(i)) begin
                m_gnt_o[i] = hs;
                s_addr_o   = m_addr_i[i];
                s_we_o     = m_we_i[i];
                s_be_o     = m_be_i[i];
                s_wdata_o  = m_wdata_i[i];
            end
            if (head_id == IDX_W'(i)) begin
                m_rvalid_o[i] = pop;
            end
            m_rdata_o[i] = s_rdata_i;
        end
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = (winner_c == IDX_W'(N_MST - 1)) ? '0 : winner_c + IDX_W'(1);
        end
        // Stalled request keeps its winner until the downstream grant arrives.
        lock_d        = s_req_o && !s_gnt_i;
        lock_idx_d    = winner_c;
        err_d         = err_q || (s_rvalid_i && fifo_empty);
        err_o         = err_q;
        outstanding_o = fifo_count;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    obi_id_fifo #(
        .ID_W  (IDX_W),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .id_i    (winner_c),
        .pop_i   (pop),
        .id_o    (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
